// File: rtl/rf_write_arbiter.sv
// Two-requester round-robin arbiter for the single register-bank write port.
// A granted requester sits out one edge, so sustained contention alternates 0,1,0,1.
module rf_write_arbiter #(
  parameter int DATA_WIDTH       = 32,
  parameter bit ZERO_REG_PROTECT = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  req0_i,
  input  logic [4:0]            addr0_i,
  input  logic [DATA_WIDTH-1:0] data0_i,
  input  logic                  req1_i,
  input  logic [4:0]            addr1_i,
  input  logic [DATA_WIDTH-1:0] data1_i,
  output logic                  gnt0_o,
  output logic                  gnt1_o,
  output logic [31:0]           load_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic                  busy_o
);

  logic                  gnt0_q, gnt0_d;
  logic                  gnt1_q, gnt1_d;
  logic [31:0]           load_q, load_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  ptr_q, ptr_d;
  logic                  elig0, elig1;
  logic [4:0]            gnt_addr;
  logic [31:0]           one_hot_base;

  assign one_hot_base = 32'd1;

  always_comb begin
    elig0    = req0_i & ~gnt0_q;
    elig1    = req1_i & ~gnt1_q;
    // ptr_q=1 means requester 1 won last, so requester 0 takes a tie
    gnt0_d   = elig0 & (~elig1 | ptr_q);
    gnt1_d   = elig1 & (~elig0 | ~ptr_q);
    gnt_addr = gnt1_d ? addr1_i : addr0_i;
    load_d   = 32'd0;
    wdata_d  = wdata_q;
    ptr_d    = ptr_q;
    if (gnt0_d || gnt1_d) begin
      wdata_d = gnt1_d ? data1_i : data0_i;
      ptr_d   = gnt1_d;
      if (!(ZERO_REG_PROTECT && (gnt_addr == 5'd0))) begin
        load_d = one_hot_base << gnt_addr;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      load_q  <= 32'd0;
      wdata_q <= '0;
      ptr_q   <= 1'b1;
    end else begin
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      load_q  <= load_d;
      wdata_q <= wdata_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt0_o  = gnt0_q;
  assign gnt1_o  = gnt1_q;
  assign load_o  = load_q;
  assign wdata_o = wdata_q;
  assign busy_o  = (req0_i & ~gnt0_q) | (req1_i & ~gnt1_q);

endmodule
